// File: rtl/blade_reader.sv
// Debounced 6-pin blade connector reader with a 2-entry change-event FIFO.
// Define BLADE_READER_OVERFLOW_EN to add the sticky overflow (event loss) output.
module blade_reader #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] blade_in,
    output logic [5:0] state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [5:0] evt_mask,
    output logic [5:0] evt_state
`ifdef BLADE_READER_OVERFLOW_EN
    ,
    output logic       overflow
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [5:0]       sync_p0;
    logic [5:0]       sync_p1;
    logic [CNT_W-1:0] cnt [6];
    logic [CNT_W-1:0] cnt_nxt [6];
    logic [5:0]       state_nxt;
    logic [5:0]       chg_nxt;
    logic [5:0]       chg_p2;
    logic             vld_p2;

    logic [5:0]       fifo_mask  [2];
    logic [5:0]       fifo_state [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // stage p0/p1: two-flop synchronizer on the raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= blade_in;
            sync_p1 <= sync_p0;
        end
    end

    // stage p2: per-pin debounce; a pin toggles on the edge its count completes
    always_comb begin
        state_nxt = state;
        chg_nxt   = '0;
        for (int i = 0; i < 6; i++) begin
            cnt_nxt[i] = '0;
            if (sync_p1[i] != state[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    state_nxt[i] = ~state[i];
                    chg_nxt[i]   = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= '0;
            chg_p2 <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            chg_p2 <= chg_nxt;
            for (int i = 0; i < 6; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // stage p3: all pins changing on one edge become a single event
    assign vld_p2 = |chg_p2;
    assign pop    = (count != 2'd0) && evt_ready;
    assign push   = vld_p2 && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mask[i]  <= '0;
                fifo_state[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mask[wr_ptr]  <= chg_p2;
                fifo_state[wr_ptr] <= state;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign evt_valid = (count != 2'd0);
    assign evt_mask  = evt_valid ? fifo_mask[rd_ptr]  : 6'd0;
    assign evt_state = evt_valid ? fifo_state[rd_ptr] : 6'd0;

`ifdef BLADE_READER_OVERFLOW_EN
    logic drop;

    // an event is lost only when the FIFO is full and nothing leaves this edge
    assign drop = vld_p2 && (count == 2'd2) && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_blade_reader.sv
// Scoreboard bench for blade_reader with a pin-history reference model (DEBOUNCE_CYCLES=4).
module tb_blade_reader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] blade_in = 6'd0;
    logic       evt_ready = 1'b0;
    logic [5:0] state;
    logic       evt_valid;
    logic [5:0] evt_mask;
    logic [5:0] evt_state;
`ifdef BLADE_READER_OVERFLOW_EN
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: pins seen two edges late, a pin flips after D straight disagreeing edges
    logic [5:0]  m_state = 6'd0;
    logic [5:0]  m_chg = 6'd0;
    logic [5:0]  m_d1 = 6'd0;
    logic [5:0]  m_d2 = 6'd0;
    int          m_run [6];
    logic        m_ovf = 1'b0;
    logic [11:0] m_fifo [$];
    logic [11:0] exp_q [$];

    blade_reader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .blade_in  (blade_in),
        .state     (state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_mask  (evt_mask),
        .evt_state (evt_state)
`ifdef BLADE_READER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_step();
        logic [5:0] nchg;
        if (reset) begin
            m_state = '0;
            m_chg   = '0;
            m_d1    = '0;
            m_d2    = '0;
            m_ovf   = 1'b0;
            for (int i = 0; i < 6; i++) m_run[i] = 0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            nchg = '0;
            if (m_fifo.size() != 0 && evt_ready) void'(m_fifo.pop_front());
            if (m_chg != 0) begin
                if (m_fifo.size() < 2) begin
                    m_fifo.push_back({m_chg, m_state});
                    exp_q.push_back({m_chg, m_state});
                end else begin
                    m_ovf = 1'b1;
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (m_d2[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_state[i] = ~m_state[i];
                        m_run[i]   = 0;
                        nchg[i]    = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_chg = nchg;
            m_d2  = m_d1;
            m_d1  = blade_in;
        end
    endtask

    task automatic monitor_step();
        chk("mon_state", {6'd0, state}, {6'd0, m_state});
        chk("mon_valid", {11'd0, evt_valid}, {11'd0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) chk("mon_head", {evt_mask, evt_state}, m_fifo[0]);
        else chk("mon_idle_payload", {evt_mask, evt_state}, 12'd0);
`ifdef BLADE_READER_OVERFLOW_EN
        chk("mon_overflow", {11'd0, overflow}, {11'd0, m_ovf});
`endif
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL delivered: got unexpected event %0h expected none at %0t",
                         {evt_mask, evt_state}, $time);
            end else begin
                chk("delivered", {evt_mask, evt_state}, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        int hold;
        repeat (3) tick();
        chk("reset_state", {6'd0, state}, 12'd0);
        chk("reset_valid", {11'd0, evt_valid}, 12'd0);
        chk("reset_payload", {evt_mask, evt_state}, 12'd0);
        reset = 1'b0;

        // basic event latency
        evt_ready = 1'b1;
        tick();
        blade_in = 6'h01;
        repeat (5) tick();
        chk("basic_state_early", {6'd0, state}, 12'h000);
        tick();
        chk("basic_state", {6'd0, state}, 12'h001);
        chk("basic_valid_early", {11'd0, evt_valid}, 12'd0);
        tick();
        chk("basic_valid", {11'd0, evt_valid}, 12'd1);
        chk("basic_payload", {evt_mask, evt_state}, {6'h01, 6'h01});
        blade_in = 6'h00;
        repeat (10) tick();

        // glitch rejection
        blade_in = 6'h04;
        repeat (3) tick();
        blade_in = 6'h00;
        repeat (8) tick();
        chk("glitch_state", {6'd0, state}, 12'd0);
        chk("glitch_valid", {11'd0, evt_valid}, 12'd0);
        chk("glitch_cnt", 12'(dut.cnt[2]), 12'd0);

        // simultaneous pins
        evt_ready = 1'b0;
        tick();
        blade_in = 6'h21;
        repeat (7) tick();
        chk("simul_valid", {11'd0, evt_valid}, 12'd1);
        chk("simul_payload", {evt_mask, evt_state}, {6'h21, 6'h21});
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick();
        chk("simul_drained", {11'd0, evt_valid}, 12'd0);

        // pop and push on the same edge with the FIFO full
        blade_in = 6'h20;
        repeat (10) tick();
        blade_in = 6'h00;
        repeat (10) tick();
        chk("full_head", {evt_mask, evt_state}, {6'h01, 6'h20});
        blade_in = 6'h04;
        repeat (6) tick();
        chk("pp_state", {6'd0, state}, 12'h004);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("pp_valid", {11'd0, evt_valid}, 12'd1);
        chk("pp_head_b", {evt_mask, evt_state}, {6'h20, 6'h00});
`ifdef BLADE_READER_OVERFLOW_EN
        chk("pp_no_overflow", {11'd0, overflow}, 12'd0);
`endif
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("pp_head_c", {evt_mask, evt_state}, {6'h04, 6'h04});
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("pp_drained", {11'd0, evt_valid}, 12'd0);

        // backpressure and drop
        blade_in = 6'h05;
        repeat (10) tick();
        blade_in = 6'h07;
        repeat (10) tick();
        blade_in = 6'h0F;
        repeat (10) tick();
        chk("bp_head", {evt_mask, evt_state}, {6'h01, 6'h05});
`ifdef BLADE_READER_OVERFLOW_EN
        chk("bp_overflow", {11'd0, overflow}, 12'd1);
`endif
        repeat (5) tick();
        chk("bp_stable", {evt_mask, evt_state}, {6'h01, 6'h05});
        chk("bp_state", {6'd0, state}, 12'h00F);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("bp_second", {evt_mask, evt_state}, {6'h02, 6'h07});
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("bp_third_dropped", {11'd0, evt_valid}, 12'd0);

        // reset mid-count with an event pending
        blade_in = 6'h0E;
        repeat (8) tick();
        chk("rst_pending", {11'd0, evt_valid}, 12'd1);
        blade_in = 6'h0C;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("rst_state", {6'd0, state}, 12'd0);
        chk("rst_valid", {11'd0, evt_valid}, 12'd0);
        chk("rst_payload", {evt_mask, evt_state}, 12'd0);
`ifdef BLADE_READER_OVERFLOW_EN
        chk("rst_overflow", {11'd0, overflow}, 12'd0);
`endif
        tick();
        reset = 1'b0;
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("rst_no_stale", {11'd0, evt_valid}, 12'd0);
        repeat (10) tick();
        chk("rst_rise_state", {6'd0, state}, 12'h00C);

        // randomized pin activity and consumer backpressure
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) blade_in = blade_in ^ 6'($urandom);
            hold = $urandom_range(1, 9);
            for (int k = 0; k < hold; k++) begin
                evt_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : ((n % 64) < 48);
                tick();
            end
        end

        evt_ready = 1'b1;
        repeat (20) tick();
        chk("scoreboard_drained", 12'(exp_q.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blade_reader.md
BLADE_READER -- requirements
Module: blade_reader

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 250000, which is the number of consecutive stable clocks needed to accept a pin change (10 ms at 25 MHz); legal range is 2 to 2^20.
REQ-002 clk  input  1  25 MHz system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 blade_in  input  6  raw asynchronous switch/button pins from a blade connector.
REQ-005 state  output  6  debounced level of each pin.
REQ-006 evt_valid  output  1  event available at the head of the FIFO.
REQ-007 evt_ready  input  1  consumer accepts the head event.
REQ-008 evt_mask  output  6  pins that changed in the head event.
REQ-009 evt_state  output  6  debounced state snapshot taken with the head event.
REQ-010 overflow  output  1  sticky event-loss flag; this port is present only with BLADE_READER_OVERFLOW_EN.

Function
REQ-011 Each blade_in bit SHALL pass through a two-flop synchronizer (sync) before any other logic.
REQ-012 Each bit SHALL have its own debounce counter.
  - The counter clears whenever sync equals state.
  - Otherwise it increments each clock.
REQ-013 When a counter has been incrementing for DEBOUNCE_CYCLES consecutive clocks, that state bit SHALL toggle on the same edge, its counter SHALL clear, and its change bit SHALL assert for exactly one clock.
REQ-014 A sync pulse shorter than DEBOUNCE_CYCLES clocks SHALL leave state unchanged.
  - The counter restarts from 0 on the next mismatch.
REQ-015 Total latency from a stable pin change to the state update SHALL be DEBOUNCE_CYCLES+2 clocks.
REQ-016 Change bits from several pins asserting in the same clock SHALL form one event (mask = OR of the change bits, snapshot = the updated state).
REQ-017 Events SHALL be stored in a 2-entry FIFO.
  - evt_valid=1 whenever the FIFO is non-empty.
  - evt_mask and evt_state show the oldest entry.
REQ-018 An event is transferred on any clock where evt_valid and evt_ready are both 1.
  - On that edge the head entry is popped.
  - The next entry, if any, appears the following cycle.
REQ-019 While evt_valid=1 and evt_ready=0, evt_mask and evt_state SHALL hold stable.
REQ-020 A new event is written 1 clock after its change bit, so evt_valid rises 1 clock after state updates when the FIFO was empty.
REQ-021 If the FIFO is full and a pop occurs in the same clock as a new event, both the pop and the push SHALL happen and no event is lost.
REQ-022 If the FIFO is full with no pop in the same clock, the new event SHALL be dropped; state still updates.
REQ-023 evt_ready while evt_valid=0 SHALL be ignored.
REQ-024 The FIFO pointers SHALL wrap modulo 2.
  - Full and empty are distinguished by an occupancy count of 0..2.

Reset
REQ-025 While reset=1, sync, state, all counters, change bits, FIFO contents and occupancy SHALL all clear to 0; evt_valid, evt_mask and evt_state SHALL read 0.
REQ-026 Reset SHALL take effect on the first clock edge where it is sampled high, including in the middle of a debounce count or while an event is pending; pending events are discarded.
REQ-027 After reset deasserts, pins held high SHALL produce a normal debounced rising event (state starts at 0).

Configuration
REQ-028 With BLADE_READER_OVERFLOW_EN defined:
  - The overflow port SHALL exist.
  - overflow SHALL be set on the clock after any drop under REQ-022.
  - overflow SHALL stay 1 until reset; its reset value is 0.
REQ-029 Without BLADE_READER_OVERFLOW_EN, the port and its logic SHALL be absent and drops SHALL be silent; all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Basic event: hold evt_ready=1 and set blade_in[0] from 0 to 1, held stable.
  - state[0]=1 exactly 6 clocks later.
  - One cycle after that, evt_valid=1, evt_mask=6'h01, evt_state=6'h01.
REQ-031 Glitch rejection: apply a 3-clock pulse on blade_in[2] → state, evt_valid and all counters are back at 0 afterwards.
REQ-032 Simultaneous pins: change blade_in from 6'h00 to 6'h21 in one clock → a single event with mask 6'h21 and snapshot 6'h21.
REQ-033 Backpressure and drop: hold evt_ready=0 and produce 3 separate events.
  - The first two are kept in order; the third is dropped.
  - overflow=1 if BLADE_READER_OVERFLOW_EN is defined.
  - Payload stays stable until the pop.
REQ-034 Pop and push together: with the FIFO full, pulse evt_ready in the same clock as a new event → the occupancy stays 2, the new event is delivered last, and overflow stays 0.
REQ-035 Reset mid-operation: assert reset mid-count with one event pending → all outputs are 0 on the next clock and no stale event appears after release.
